ecc_result_scoreboard: RTL and testbench

- Synthesisable, parametrised scoreboard for the ECC encode/decode/full-channel datapath.
- Holds a queue of expected results and compares each against the DUT result on every operation_done rising edge.
- Keeps saturating per-mode hit/miss counters, captures the first mismatch, and flags underflow and timeouts.
- Sits beside the DUT in the verification top; can also be kept in an emulation build.

---
 rtl/ecc_sb_pkg.sv | 15 +
 rtl/sb_sync_fifo.sv | 37 +++
 rtl/ecc_result_scoreboard.sv | 134 +++++++++++++
 tb/tb_ecc_result_scoreboard.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ecc_sb_pkg.sv
// ecc_sb_pkg: shared modes, FSM states and statistics register map for the ECC result scoreboard
package ecc_sb_pkg;
  localparam logic [1:0] MODE_ENCODE       = 2'd0;
  localparam logic [1:0] MODE_DECODE       = 2'd1;
  localparam logic [1:0] MODE_FULL_CHANNEL = 2'd2;
  localparam logic [1:0] MODE_RESERVED     = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FAULT = 2'd2} sb_state_t;
  localparam logic [3:0] ADDR_HIT0      = 4'd0;
  localparam logic [3:0] ADDR_MISS0     = 4'd3;
  localparam logic [3:0] ADDR_UNDERFLOW = 4'd6;
  localparam logic [3:0] ADDR_STATUS    = 4'd7;
  localparam logic [3:0] ADDR_MM_EXP    = 4'd8;
  localparam logic [3:0] ADDR_MM_DUT    = 4'd9;
  localparam logic [3:0] ADDR_MM_MODE   = 4'd10;
endpackage

// File: rtl/sb_sync_fifo.sv
// sb_sync_fifo: synchronous FIFO with full/empty/level; pushes while full and pops while empty are ignored
module sb_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rdPtr];
  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop) rdPtr <= rdPtr + AW'(1);
      level <= level + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
endmodule

// File: rtl/ecc_result_scoreboard.sv
// ecc_result_scoreboard: expected-result queue, per-mode hit/miss statistics and fault flagging for the ECC datapath; define SB_TIMEOUT_EN to add the idle watchdog
module ecc_result_scoreboard
  import ecc_sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ERR_WIDTH = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [1:0]            exp_mode,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic [ERR_WIDTH-1:0]  exp_errors,
  input  logic                  operation_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [ERR_WIDTH-1:0]  num_of_errors,
  input  logic                  stat_clr,
  input  logic [3:0]            rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  cmp_valid,
  output logic                  cmp_hit,
  output logic                  sb_error
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  typedef struct packed {
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] data;
    logic [ERR_WIDTH-1:0]  errors;
  } entry_t;
  entry_t head;
  logic [$bits(entry_t)-1:0] headRaw;
  logic doneQ, evt, pushFire, cmpEvt, underflow, reserved, hit, errCond, toEvent, timeout, sbErr, full, empty, mmSeen;
  logic [LW-1:0] level, levelNext;
  logic [1:0] cntIdx, mmMode;
  logic [CNT_WIDTH-1:0] hitCnt [3];
  logic [CNT_WIDTH-1:0] missCnt [3];
  logic [CNT_WIDTH-1:0] undCnt;
  logic [DATA_WIDTH-1:0] mmExp, mmDut, rdMux;
  sb_state_t state, stateNext;
  sb_sync_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(exp_valid), .pop(evt),
    .wdata({exp_mode, exp_data, exp_errors}), .rdata(headRaw),
    .full(full), .empty(empty), .level(level)
  );
  assign head = entry_t'(headRaw);
  assign exp_ready = !full;
  assign evt = operation_done && !doneQ;
  assign pushFire = exp_valid && !full;
  assign cmpEvt = evt && !empty;
  assign underflow = evt && empty;
  assign reserved = cmpEvt && head.mode == MODE_RESERVED;
  assign cntIdx = head.mode == MODE_RESERVED ? MODE_FULL_CHANNEL : head.mode;
  // double errors on both sides count as a hit whatever the data says
  assign hit = head.mode != MODE_RESERVED &&
               ((head.data == data_out && (head.mode == MODE_ENCODE || head.errors == num_of_errors)) ||
                (head.mode != MODE_ENCODE && head.errors == ERR_WIDTH'(2) && num_of_errors == ERR_WIDTH'(2)));
  assign errCond = underflow || reserved || toEvent;
  assign levelNext = level + LW'(pushFire) - LW'(cmpEvt);
  assign sb_error = sbErr;
  always_ff @(posedge clk)
    doneQ <= rst ? 1'b0 : operation_done;
  always_ff @(posedge clk)
    state <= rst ? IDLE : stateNext;
  always_comb
    stateNext = stat_clr ? (levelNext == '0 ? IDLE : ACTIVE) :
                (errCond || state == FAULT) ? FAULT :
                levelNext == '0 ? IDLE : ACTIVE;
  always_ff @(posedge clk)
    if (rst || stat_clr) begin
      hitCnt <= '{default: '0};
      missCnt <= '{default: '0};
      undCnt <= '0;
      mmSeen <= 1'b0;
      mmExp <= '0;
      mmDut <= '0;
      mmMode <= '0;
      sbErr <= 1'b0;
    end else begin
      if (cmpEvt && hit && hitCnt[cntIdx] != CNT_MAX) hitCnt[cntIdx] <= hitCnt[cntIdx] + CNT_WIDTH'(1);
      if (cmpEvt && !hit && missCnt[cntIdx] != CNT_MAX) missCnt[cntIdx] <= missCnt[cntIdx] + CNT_WIDTH'(1);
      if (underflow && undCnt != CNT_MAX) undCnt <= undCnt + CNT_WIDTH'(1);
      if (cmpEvt && !hit && !mmSeen) begin
        mmSeen <= 1'b1;
        mmExp <= head.data;
        mmDut <= data_out;
        mmMode <= head.mode;
      end
      if (errCond) sbErr <= 1'b1;
    end
`ifdef SB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdCnt;
  assign toEvent = state == ACTIVE && !evt && !pushFire && wdCnt == WW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || stat_clr || evt || pushFire) wdCnt <= '0;
    else if (state == ACTIVE && wdCnt != WW'(TIMEOUT_CYCLES)) wdCnt <= wdCnt + WW'(1);
  always_ff @(posedge clk)
    if (rst || stat_clr) timeout <= 1'b0;
    else if (toEvent) timeout <= 1'b1;
`else
  assign toEvent = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb
    case (rd_addr)
      ADDR_HIT0:             rdMux = DATA_WIDTH'(hitCnt[0]);
      ADDR_HIT0 + 4'd1:      rdMux = DATA_WIDTH'(hitCnt[1]);
      ADDR_HIT0 + 4'd2:      rdMux = DATA_WIDTH'(hitCnt[2]);
      ADDR_MISS0:            rdMux = DATA_WIDTH'(missCnt[0]);
      ADDR_MISS0 + 4'd1:     rdMux = DATA_WIDTH'(missCnt[1]);
      ADDR_MISS0 + 4'd2:     rdMux = DATA_WIDTH'(missCnt[2]);
      ADDR_UNDERFLOW:        rdMux = DATA_WIDTH'(undCnt);
      ADDR_STATUS:           rdMux = DATA_WIDTH'({state, level, timeout, sbErr});
      ADDR_MM_EXP:           rdMux = mmExp;
      ADDR_MM_DUT:           rdMux = mmDut;
      ADDR_MM_MODE:          rdMux = DATA_WIDTH'(mmMode);
      default:               rdMux = '0;
    endcase
  always_ff @(posedge clk)
    if (rst) begin
      cmp_valid <= 1'b0;
      cmp_hit <= 1'b0;
      rd_data <= '0;
    end else begin
      cmp_valid <= cmpEvt && !stat_clr;
      cmp_hit <= cmpEvt && !stat_clr && hit;
      rd_data <= rdMux;
    end
endmodule

// File: tb/tb_ecc_result_scoreboard.sv
// tb_ecc_result_scoreboard: directed stimulus checked every cycle against a queue-based reference model
module tb_ecc_result_scoreboard;
  import ecc_sb_pkg::*;
  localparam int DW = 32, EW = 2, DEPTH = 8, CW = 4, TO = 16;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SB_TIMEOUT_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, exp_valid, exp_ready, operation_done, stat_clr, cmp_valid, cmp_hit, sb_error;
  logic [1:0] exp_mode;
  logic [DW-1:0] exp_data, data_out, rd_data;
  logic [EW-1:0] exp_errors, num_of_errors;
  logic [3:0] rd_addr;
  int total = 0, bad = 0, hitPulses = 0;
  always #5 clk = ~clk;
  ecc_result_scoreboard #(.DATA_WIDTH(DW), .ERR_WIDTH(EW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_mode(exp_mode),
    .exp_data(exp_data), .exp_errors(exp_errors), .operation_done(operation_done),
    .data_out(data_out), .num_of_errors(num_of_errors), .stat_clr(stat_clr), .rd_addr(rd_addr),
    .rd_data(rd_data), .cmp_valid(cmp_valid), .cmp_hit(cmp_hit), .sb_error(sb_error)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, act, req, $time);
    end
  endtask
  // reference model: what the scoreboard must report, from the rules alone
  typedef struct {logic [1:0] mode; logic [31:0] data; logic [1:0] err;} ent_t;
  ent_t q[$];
  int mHit[3], mMiss[3], mUnd, mIdle;
  bit mSeen, mErr, mTo, mPrev, eValid, eHit;
  logic [31:0] mmE, mmD, eRd;
  logic [1:0] mmM;
  function automatic bit judge(ent_t e, logic [31:0] d, logic [1:0] er);
    if (e.mode == 2'd0) return e.data == d;
    if (e.mode == 2'd3) return 1'b0;
    return (e.data == d && e.err == er) || (e.err == 2'd2 && er == 2'd2);
  endfunction
  function automatic int stateNow();
    return mErr ? int'(FAULT) : (q.size() != 0 ? int'(ACTIVE) : int'(IDLE));
  endfunction
  function automatic logic [31:0] readModel(logic [3:0] a);
    if (a <= 4'd2) return 32'(mHit[a]);
    if (a <= 4'd5) return 32'(mMiss[a - 4'd3]);
    if (a == 4'd6) return 32'(mUnd);
    if (a == 4'd7) return 32'((stateNow() << 6) | (q.size() << 2) | (int'(mTo) << 1) | int'(mErr));
    if (a == 4'd8) return mmE;
    if (a == 4'd9) return mmD;
    if (a == 4'd10) return 32'(mmM);
    return 32'h0;
  endfunction
  task automatic clearStats();
    mHit = '{0, 0, 0}; mMiss = '{0, 0, 0}; mUnd = 0;
    mSeen = 0; mmE = 0; mmD = 0; mmM = 0; mErr = 0; mTo = 0;
  endtask
  always @(posedge clk) begin
    bit evt, pushOk, errNow, toNow, h;
    int st, idx;
    ent_t e;
    if (rst) begin
      q.delete(); clearStats(); mPrev = 0; mIdle = 0; eValid = 0; eHit = 0; eRd = 0;
    end else begin
      eRd = readModel(rd_addr);
      st = stateNow();
      evt = operation_done && !mPrev;
      mPrev = operation_done;
      pushOk = exp_valid && q.size() < DEPTH;
      eValid = 0; eHit = 0; errNow = 0; toNow = 0;
      if (evt && q.size() == 0) begin
        errNow = 1;
        if (!stat_clr && mUnd < CMAX) mUnd++;
      end else if (evt) begin
        e = q.pop_front();
        h = judge(e, data_out, num_of_errors);
        idx = e.mode == 2'd3 ? 2 : int'(e.mode);
        if (e.mode == 2'd3) errNow = 1;
        eValid = !stat_clr; eHit = h && !stat_clr;
        if (!stat_clr && h && mHit[idx] < CMAX) mHit[idx]++;
        if (!stat_clr && !h && mMiss[idx] < CMAX) mMiss[idx]++;
        if (!stat_clr && !h && !mSeen) begin mSeen = 1; mmE = e.data; mmD = data_out; mmM = e.mode; end
      end
      if (evt || pushOk || stat_clr) mIdle = 0;
      else if (WD_ON && st == int'(ACTIVE) && mIdle < TO) begin
        mIdle++;
        if (mIdle == TO) begin errNow = 1; toNow = 1; end
      end
      if (pushOk) q.push_back('{exp_mode, exp_data, exp_errors});
      if (stat_clr) clearStats();
      else if (errNow) begin mErr = 1; if (toNow) mTo = 1; end
    end
  end
  always @(posedge clk) begin
    #1;
    chk("exp_ready", 32'(exp_ready), 32'(q.size() < DEPTH));
    chk("cmp_valid", 32'(cmp_valid), 32'(eValid));
    if (eValid) chk("cmp_hit", 32'(cmp_hit), 32'(eHit));
    chk("sb_error", 32'(sb_error), 32'(mErr));
    chk("rd_data", rd_data, eRd);
    if (cmp_valid && cmp_hit) hitPulses++;
  end
  task automatic pushE(input logic [1:0] m, input logic [31:0] d, input logic [1:0] er);
    @(negedge clk); exp_valid = 1; exp_mode = m; exp_data = d; exp_errors = er;
    @(negedge clk); exp_valid = 0;
  endtask
  task automatic doneE(input logic [31:0] d, input logic [1:0] er);
    @(negedge clk); operation_done = 1; data_out = d; num_of_errors = er;
    @(negedge clk); operation_done = 0;
  endtask
  task automatic readReg(input logic [3:0] a, input logic [31:0] req, input string n);
    @(negedge clk); rd_addr = a;
    @(posedge clk); #1; chk(n, rd_data, req);
  endtask
  task automatic clr();
    @(negedge clk); stat_clr = 1;
    @(negedge clk); stat_clr = 0;
  endtask
  initial begin
    #300000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    rst = 1; exp_valid = 0; exp_mode = 0; exp_data = 0; exp_errors = 0; operation_done = 0;
    data_out = 0; num_of_errors = 0; stat_clr = 0; rd_addr = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(exp_ready), 1); chk("rst_rd", rd_data, 0);
    chk("rst_valid", 32'(cmp_valid), 0); chk("rst_hit", 32'(cmp_hit), 0);
    chk("rst_err", 32'(sb_error), 0);
    hitPulses = 0;
    pushE(0, 32'hA5, 0); pushE(0, 32'h3C, 0); pushE(0, 32'hFF, 0);
    doneE(32'hA5, 0); doneE(32'h3C, 0); doneE(32'hFF, 0);
    readReg(0, 3, "hit0"); readReg(3, 0, "miss0"); readReg(7, 0, "status_idle");
    chk("hit_pulses", 32'(hitPulses), 3);
    pushE(1, 32'h12, 1); doneE(32'h13, 1);
    readReg(4, 1, "miss1"); readReg(8, 32'h12, "mm_exp"); readReg(9, 32'h13, "mm_dut"); readReg(10, 1, "mm_mode");
    pushE(1, 32'h20, 0); doneE(32'h21, 0);
    readReg(4, 2, "miss1_again"); readReg(8, 32'h12, "mm_exp_kept"); readReg(9, 32'h13, "mm_dut_kept");
    pushE(2, 32'h55, 2); doneE(32'h00, 2);
    readReg(2, 1, "hit2_double"); readReg(5, 0, "miss2_none");
    @(negedge clk); operation_done = 1; data_out = 0;
    repeat (5) @(negedge clk); operation_done = 0;
    readReg(6, 1, "underflow_once"); readReg(7, 32'h81, "status_fault");
    chk("fault_err", 32'(sb_error), 1);
    clr();
    readReg(6, 0, "clr_und"); readReg(4, 0, "clr_miss1"); readReg(8, 0, "clr_mm"); readReg(7, 0, "clr_status");
    for (int i = 0; i < 8; i++) pushE(0, 32'(i), 0);
    chk("full_ready", 32'(exp_ready), 0);
    pushE(0, 32'd99, 0);
    readReg(7, 32'h60, "status_full");
    doneE(0, 0);
    @(negedge clk); exp_valid = 1; exp_mode = 0; exp_data = 8; exp_errors = 0;
    operation_done = 1; data_out = 1; num_of_errors = 0;
    @(negedge clk); exp_valid = 0; operation_done = 0;
    readReg(7, 32'h5C, "status_lvl7");
    for (int i = 2; i <= 8; i++) doneE(32'(i), 0);
    for (int i = 0; i < 8; i++) begin pushE(0, 32'(i + 40), 0); doneE(32'(i + 40), 0); end
    readReg(0, CMAX, "hit0_sat"); readReg(3, 0, "miss0_after_fill"); readReg(7, 0, "status_drained");
    pushE(0, 32'h77, 0);
    repeat (20) @(negedge clk);
    readReg(7, WD_ON ? 32'h87 : 32'h44, "status_timeout");
    chk("timeout_err", 32'(sb_error), 32'(WD_ON));
    clr(); doneE(32'h77, 0);
    pushE(3, 32'h1, 0); doneE(32'h1, 0);
    readReg(5, 1, "reserved_miss2"); readReg(7, 32'h81, "reserved_fault");
    clr();
    pushE(1, 32'h5, 1); pushE(1, 32'h6, 1);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    readReg(7, 0, "rst_mid_status");
    chk("rst_mid_ready", 32'(exp_ready), 1);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
